if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU.
- Holds the PC and drives the instruction-memory address.
- Latches fetched instructions into IF/ID; the IF/ID instruction is the instruction input of the hazard-detection unit.
- Consumes that unit's active-high hazard (stall) and the branch/jump redirect from later stages.

Parameters:
PC_WIDTH, 16, width of PC and instruction-memory address.
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OP, 4'hF, opcode (bits [15:12]) of the halt instruction.
NOP_INSTR, 16'h0000, bubble inserted on flush/halt (ADD R0,R0,R0; R0 hardwired zero).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
hazard  input  1  stall request from hazard detection; hold PC and IF/ID.
redirect_valid  input  1  branch/jump taken; squash fetch and load redirect_pc.
redirect_pc  input  PC_WIDTH  target PC for redirect.
imem_addr  output  PC_WIDTH  instruction-memory address, equals current PC (combinational from PC reg).
imem_data  input  16  instruction word read combinationally at imem_addr.
if_id_instr  output  16  IF/ID instruction register.
if_id_pc1  output  PC_WIDTH  IF/ID copy of PC+1 of the latched instruction.
if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction.
halted  output  1  high while FSM is in HALT.
stall_cycles  output  16  stall counter (see Optional Feature).
flush_count  output  16  redirect counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge) is synchronous and overrides everything:
  - PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc1=0, if_id_valid=0.
  - State=RUN, halted=0, counters=0.
- FSM states: RUN, HALT.
- Per-posedge priority: rst > redirect_valid > hazard > normal advance.
- Redirect (any state):
  - PC<=redirect_pc, if_id_instr<=NOP_INSTR, if_id_valid<=0, state<=RUN.
  - Redirect wins over a simultaneous hazard; the redirecting instruction is older, so the stalled one is squashed.
- Hazard, no redirect: PC, if_id_instr, if_id_pc1, if_id_valid and state all hold unchanged.
  - imem_addr stays stable, so the same word is re-presented next cycle.
- RUN, normal advance:
  - PC<=PC+1, if_id_instr<=imem_data, if_id_pc1<=PC+1, if_id_valid<=1.
  - If imem_data[15:12]==HALT_OP: the halt word is latched into IF/ID and state<=HALT. PC does not increment on this edge; PC stays at the halt address.
- HALT, normal advance:
  - PC holds; if_id_instr<=NOP_INSTR, if_id_valid<=0; halted=1.
  - Only rst or redirect_valid leave HALT.
- PC arithmetic is modulo 2^PC_WIDTH: PC=16'hFFFF advances to 16'h0000, if_id_pc1=16'h0000.
- Latency: an instruction at address A appears on if_id_instr one edge after imem_addr==A with no stall. Each stall cycle adds exactly one cycle.
- Consecutive hazard cycles hold IF/ID indefinitely; no bubble is generated by this block. The ID/EX bubble belongs to the control unit.
- halted is a registered output, asserted from the edge after the halt word is latched.

Optional Feature:
Macro: IF_STAGE_PERF_CNT_EN
- Defined:
  - stall_cycles increments (saturating at 16'hFFFF) on each edge where hazard=1, redirect_valid=0, rst=0.
  - flush_count increments (saturating) on each edge with redirect_valid=1, rst=0.
  - Both are cleared by rst.
- Not defined: no counter registers are synthesized; stall_cycles and flush_count are tied to 16'h0000. Port list is unchanged.

Test Plan:
- Reset, then imem returns 16'h1234 at addr 0 and 16'h5678 at addr 1, no hazard -> edge 1: if_id_instr=16'h1234, if_id_pc1=1, valid=1, imem_addr=1; edge 2: 16'h5678, pc1=2.
- hazard=1 for 2 cycles with PC=3 -> PC, imem_addr=3, if_id_instr and valid held both cycles; with IF_STAGE_PERF_CNT_EN stall_cycles=2.
- redirect_valid=1, redirect_pc=16'h0040, hazard=1 same cycle -> next edge PC=16'h0040, if_id_instr=16'h0000, valid=0; flush_count=1 (macro on), stall_cycles unchanged.
- imem_data=16'hF000 at PC=5 -> IF/ID=16'hF000, valid=1, PC stays 5; following edges if_id_instr=16'h0000, valid=0, halted=1. Then redirect_pc=16'h0010 -> halted=0, PC=16'h0010.
- PC=16'hFFFF, normal advance -> PC=16'h0000, if_id_pc1=16'h0000.
- rst asserted mid-stall with hazard=1 and redirect_valid=1 -> PC=RESET_PC, if_id_instr=16'h0000, valid=0, state RUN, counters 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register and RUN/HALT FSM.
// Optional perf counters enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter int              PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP   = 4'hF,
  parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc1,
  output logic                if_id_valid,
  output logic                halted,
  output logic [15:0]         stall_cycles,
  output logic [15:0]         flush_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc1_q, pc1_d, pc_inc;
  logic [15:0] instr_q, instr_d;
  logic valid_q, valid_d, is_halt;
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign is_halt = imem_data[15:12] == HALT_OP;
  always_comb begin
    pc_d    = pc_q;
    pc1_d   = pc1_q;
    instr_d = instr_q;
    valid_d = valid_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (!hazard) begin
      // The halt word itself is latched; PC parks on its address.
      pc_d    = (state_q == RUN && !is_halt) ? pc_inc : pc_q;
      instr_d = (state_q == RUN) ? imem_data : NOP_INSTR;
      pc1_d   = (state_q == RUN) ? pc_inc : pc1_q;
      valid_d = state_q == RUN;
      state_d = (state_q == RUN && is_halt) ? HALT : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc1_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      pc1_q   <= pc1_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = state_q == HALT;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (redirect_valid) flush_q <= flush_q + {15'b0, ~&flush_q};
      else if (hazard) stall_q <= stall_q + {15'b0, ~&stall_q};
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 16'h0000;
  assign flush_count  = 16'h0000;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall, redirect, halt, wrap and reset.
module tb_if_stage;
`ifdef IF_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, hazard = 1'b0, redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0, imem_addr, imem_data, if_id_instr, if_id_pc1;
  logic if_id_valid, halted;
  logic [15:0] stall_cycles, flush_count;
  logic [15:0] mem [0:255];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[7:0]];

  if_stage dut (.clk(clk), .rst(rst), .hazard(hazard), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pc(input int n);
    return PERF ? 16'(n) : 16'h0000;
  endfunction

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
    checks++; if (if_id_instr !== 16'h0000 || if_id_valid !== 1'b0 || if_id_pc1 !== 16'h0000) begin failures++; $display("FAIL rst_ifid got=%h/%b/%h exp=0000/0/0000", if_id_instr, if_id_valid, if_id_pc1); end
    checks++; if (halted !== 1'b0 || stall_cycles !== 16'h0 || flush_count !== 16'h0) begin failures++; $display("FAIL rst_misc got=%b/%h/%h exp=0/0000/0000", halted, stall_cycles, flush_count); end
  endtask

  task automatic test_advance();
    step();
    checks++; if (if_id_instr !== 16'h1234 || if_id_pc1 !== 16'h0001 || if_id_valid !== 1'b1 || imem_addr !== 16'h0001) begin failures++; $display("FAIL adv1 got=%h/%h/%b/%h exp=1234/0001/1/0001", if_id_instr, if_id_pc1, if_id_valid, imem_addr); end
    step();
    checks++; if (if_id_instr !== 16'h5678 || if_id_pc1 !== 16'h0002 || imem_addr !== 16'h0002) begin failures++; $display("FAIL adv2 got=%h/%h/%h exp=5678/0002/0002", if_id_instr, if_id_pc1, imem_addr); end
    step();
    checks++; if (if_id_instr !== 16'h1111 || if_id_pc1 !== 16'h0003 || imem_addr !== 16'h0003) begin failures++; $display("FAIL adv3 got=%h/%h/%h exp=1111/0003/0003", if_id_instr, if_id_pc1, imem_addr); end
  endtask

  task automatic test_hazard();
    hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_addr !== 16'h0003 || if_id_instr !== 16'h1111 || if_id_valid !== 1'b1 || if_id_pc1 !== 16'h0003) begin failures++; $display("FAIL hz_hold%0d got=%h/%h/%b/%h exp=0003/1111/1/0003", i, imem_addr, if_id_instr, if_id_valid, if_id_pc1); end
    end
    checks++; if (stall_cycles !== pc(2)) begin failures++; $display("FAIL hz_cnt got=%h exp=%h", stall_cycles, pc(2)); end
    hazard = 1'b0; step();
    checks++; if (if_id_instr !== 16'h2222 || imem_addr !== 16'h0004 || if_id_pc1 !== 16'h0004) begin failures++; $display("FAIL hz_release got=%h/%h/%h exp=2222/0004/0004", if_id_instr, imem_addr, if_id_pc1); end
  endtask

  task automatic test_redirect();
    hazard = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040; step();
    hazard = 1'b0; redirect_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0040 || if_id_instr !== 16'h0000 || if_id_valid !== 1'b0) begin failures++; $display("FAIL rd_squash got=%h/%h/%b exp=0040/0000/0", imem_addr, if_id_instr, if_id_valid); end
    checks++; if (flush_count !== pc(1) || stall_cycles !== pc(2)) begin failures++; $display("FAIL rd_cnt got=%h/%h exp=%h/%h", flush_count, stall_cycles, pc(1), pc(2)); end
    step();
    checks++; if (if_id_instr !== 16'h3333 || if_id_pc1 !== 16'h0041 || if_id_valid !== 1'b1) begin failures++; $display("FAIL rd_fetch got=%h/%h/%b exp=3333/0041/1", if_id_instr, if_id_pc1, if_id_valid); end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1; redirect_pc = 16'h0005; step(); redirect_valid = 1'b0;
    step();
    checks++; if (if_id_instr !== 16'hF000 || if_id_valid !== 1'b1 || imem_addr !== 16'h0005) begin failures++; $display("FAIL halt_latch got=%h/%b/%h exp=f000/1/0005", if_id_instr, if_id_valid, imem_addr); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (if_id_instr !== 16'h0000 || if_id_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 16'h0005) begin failures++; $display("FAIL halt_hold%0d got=%h/%b/%b/%h exp=0000/0/1/0005", i, if_id_instr, if_id_valid, halted, imem_addr); end
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0010; step(); redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0010 || flush_count !== pc(3)) begin failures++; $display("FAIL halt_exit got=%b/%h/%h exp=0/0010/%h", halted, imem_addr, flush_count, pc(3)); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF; step(); redirect_valid = 1'b0;
    step();
    checks++; if (imem_addr !== 16'h0000 || if_id_pc1 !== 16'h0000 || if_id_instr !== 16'h4444) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=0000/0000/4444", imem_addr, if_id_pc1, if_id_instr); end
  endtask

  task automatic test_rst_mid_stall();
    hazard = 1'b1; step();
    checks++; if (stall_cycles !== pc(3)) begin failures++; $display("FAIL pre_rst_cnt got=%h exp=%h", stall_cycles, pc(3)); end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0077; step();
    rst = 1'b0; hazard = 1'b0; redirect_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0000 || if_id_instr !== 16'h0000 || if_id_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL mid_rst got=%h/%h/%b/%b exp=0000/0000/0/0", imem_addr, if_id_instr, if_id_valid, halted); end
    checks++; if (stall_cycles !== 16'h0 || flush_count !== 16'h0) begin failures++; $display("FAIL mid_rst_cnt got=%h/%h exp=0000/0000", stall_cycles, flush_count); end
    step();
    checks++; if (if_id_instr !== 16'h1234 || if_id_valid !== 1'b1 || imem_addr !== 16'h0001) begin failures++; $display("FAIL post_rst_run got=%h/%b/%h exp=1234/1/0001", if_id_instr, if_id_valid, imem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100;
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h1111; mem[3] = 16'h2222;
    mem[5] = 16'hF000; mem[8'h40] = 16'h3333; mem[8'hFF] = 16'h4444;
    test_reset();
    test_advance();
    test_hazard();
    test_redirect();
    test_halt();
    test_wrap();
    test_rst_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
